sdram_port_arbiter: RTL and testbench

//  Shares the single SDRAM controller port between N_REQ cores (MixCore, record, play, GUI loader).

---
 rtl/sdram_port_arbiter_if.sv | 51 +++++
 rtl/sdram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter_if
// Purpose  : Bundles the requester-side and controller-side buses of the
//            SDRAM port arbiter. The "slave" modport is the arbiter's view;
//            the "master" modport is the surrounding environment (requesters
//            plus SDRAM controller wrapper).
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_port_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  // Requester side
  logic [N_REQ-1:0]             req_read;
  logic [N_REQ-1:0]             req_write;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]            req_readdata;
  logic [N_REQ-1:0]             req_finished;

  // Controller side
  logic                         sdram_read;
  logic                         sdram_write;
  logic [ADDR_W-1:0]            sdram_addr;
  logic [DATA_W-1:0]            sdram_writedata;
  logic [DATA_W-1:0]            sdram_readdata;
  logic                         sdram_finished;

  // Status
  logic [N_REQ-1:0]             arb_grant;
  logic                         arb_timeout;

  modport slave (
    input  req_read, req_write, req_addr, req_writedata,
    input  sdram_readdata, sdram_finished,
    output req_readdata, req_finished,
    output sdram_read, sdram_write, sdram_addr, sdram_writedata,
    output arb_grant, arb_timeout
  );

  modport master (
    output req_read, req_write, req_addr, req_writedata,
    output sdram_readdata, sdram_finished,
    input  req_readdata, req_finished,
    input  sdram_read, sdram_write, sdram_addr, sdram_writedata,
    input  arb_grant, arb_timeout
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Round-robin arbiter sharing one SDRAM controller port between
//            N_REQ requesters. A grant is held until the controller reports
//            finished or the granted requester withdraws its request.
//            Optional watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sdram_port_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Reject configurations the pointer arithmetic is not sized for
  generate
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_params
      $error("sdram_port_arbiter: N_REQ must be 2..8 and TIMEOUT >= 2");
    end
  endgenerate

  logic [0:0]       state_q,  state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gidx_q,   gidx_d;
  logic [N_REQ-1:0] grant_q,  grant_d;

  logic [N_REQ-1:0] active;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W:0]   cand;
  logic             busy;
  logic             g_read;
  logic             g_write;
  logic             g_active;
  logic [PTR_W-1:0] g_next;
  logic             tmo_hit;

  assign active   = bus.req_read | bus.req_write;
  assign busy     = (state_q == ST_BUSY);
  assign g_read   = bus.req_read[gidx_q];
  assign g_write  = bus.req_write[gidx_q];
  assign g_active = g_read | g_write;
  assign g_next   = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // Find the first active requester starting at rr_ptr, wrapping mod N_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(N_REQ)) begin
        cand = cand - (PTR_W + 1)'(N_REQ);
      end
      if (!pick_found && active[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              arb_timeout_q, arb_timeout_d;

  // Watchdog: fires on the last allowed BUSY cycle unless that cycle already ends the grant
  assign tmo_hit = busy && (wdog_q == WDOG_W'(TIMEOUT - 1))
                   && !bus.sdram_finished && g_active;

  // Count BUSY cycles; restart from zero on every new grant
  always_comb begin
    wdog_d        = '0;
    arb_timeout_d = tmo_hit;
    if (busy && !tmo_hit) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wdog_q        <= '0;
      arb_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      arb_timeout_q <= arb_timeout_d;
    end
  end

  assign bus.arb_timeout = arb_timeout_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.arb_timeout = 1'b0;
`endif

  // Grant selection in IDLE; release on finished, withdrawal or watchdog in BUSY
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          gidx_d  = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
        end
      end
      ST_BUSY: begin
        if (bus.sdram_finished || !g_active || tmo_hit) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = g_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
    end
  end

  // Pass the granted requester's command through; read wins over write
  assign bus.sdram_read      = busy & g_read;
  assign bus.sdram_write     = busy & g_write & ~g_read;
  assign bus.sdram_addr      = busy ? bus.req_addr[gidx_q]      : '0;
  assign bus.sdram_writedata = busy ? bus.req_writedata[gidx_q] : '0;

  assign bus.req_finished    = (busy && bus.sdram_finished) ? grant_q : '0;
  assign bus.req_readdata    = bus.sdram_readdata;
  assign bus.arb_grant       = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Directed self-checking bench for sdram_port_arbiter
//            (N_REQ=4, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  sdram_port_arbiter_if #(.N_REQ(4), .ADDR_W(23), .DATA_W(32)) bus ();

  sdram_port_arbiter #(
    .N_REQ(4), .ADDR_W(23), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_addr       = '0;
    bus.req_writedata  = '0;
    bus.sdram_readdata = '0;
    bus.sdram_finished = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (bus.arb_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.arb_grant); end
    n_checks++; if (bus.sdram_read !== 1'b0 || bus.sdram_write !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got r=%b w=%b want 0 0", bus.sdram_read, bus.sdram_write); end
    n_checks++; if (bus.req_finished !== 4'b0000 || bus.arb_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_status: got fin=%b tmo=%b want 0000 0", bus.req_finished, bus.arb_timeout); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.req_read[0] = 1'b1;
    bus.req_addr[0] = 23'h000123;
    #1;
    n_checks++; if (bus.sdram_read !== 1'b0) begin n_fail++; $display("FAIL single_idle_cmd: got %b want 0", bus.sdram_read); end
    step();
    n_checks++; if (bus.sdram_read !== 1'b1 || bus.sdram_addr !== 23'h000123) begin n_fail++; $display("FAIL single_cmd: got r=%b a=%h want 1 000123", bus.sdram_read, bus.sdram_addr); end
    n_checks++; if (bus.arb_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.arb_grant); end
    bus.sdram_finished = 1'b1;
    bus.sdram_readdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (bus.req_finished !== 4'b0001) begin n_fail++; $display("FAIL single_finished: got %b want 0001", bus.req_finished); end
    n_checks++; if (bus.req_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_readdata: got %h want deadbeef", bus.req_readdata); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (bus.arb_grant !== 4'b0000 || bus.sdram_read !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got g=%b r=%b want 0000 0", bus.arb_grant, bus.sdram_read); end
    step();
  endtask

  task automatic test_finished_idle();
    bus.sdram_finished = 1'b1;
    #1;
    n_checks++; if (bus.req_finished !== 4'b0000) begin n_fail++; $display("FAIL idle_finished: got %b want 0000", bus.req_finished); end
    step();
    n_checks++; if (bus.arb_grant !== 4'b0000) begin n_fail++; $display("FAIL idle_finished_grant: got %b want 0000", bus.arb_grant); end
    bus.sdram_finished = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_read[i] = 1'b1;
      bus.req_addr[i] = 23'(32'h100 * (i + 1));
    end
    step();  // IDLE cycle scanning
    for (int n = 0; n < 5; n++) begin
      step();  // command cycle c
      exp_g = 4'b0001 << order[n];
      n_checks++; if (bus.arb_grant !== exp_g || bus.sdram_read !== 1'b1) begin n_fail++; $display("FAIL rr_grant[%0d]: got g=%b r=%b want %b 1", n, bus.arb_grant, bus.sdram_read, exp_g); end
      n_checks++; if (bus.sdram_addr !== 23'(32'h100 * (order[n] + 1))) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", n, bus.sdram_addr, 23'(32'h100 * (order[n] + 1))); end
      step();
      step();
      step();  // c+3
      n_checks++; if (bus.arb_grant !== exp_g) begin n_fail++; $display("FAIL rr_hold[%0d]: got %b want %b", n, bus.arb_grant, exp_g); end
      bus.sdram_finished = 1'b1;
      #1;
      n_checks++; if (bus.req_finished !== exp_g) begin n_fail++; $display("FAIL rr_finished[%0d]: got %b want %b", n, bus.req_finished, exp_g); end
      step();  // c+4, IDLE bubble
      bus.sdram_finished = 1'b0;
      if (n == 4) bus.req_read = '0;
      #1;
      n_checks++; if (bus.arb_grant !== 4'b0000 || bus.sdram_read !== 1'b0) begin n_fail++; $display("FAIL rr_bubble[%0d]: got g=%b r=%b want 0000 0", n, bus.arb_grant, bus.sdram_read); end
    end
    step();
    n_checks++; if (bus.arb_grant !== 4'b0000) begin n_fail++; $display("FAIL rr_end_idle: got %b want 0000", bus.arb_grant); end
    clear_inputs();
  endtask

  // rr_ptr is 1 on entry (last grant was 0)
  task automatic test_read_write();
    bus.req_read[2]      = 1'b1;
    bus.req_write[2]     = 1'b1;
    bus.req_addr[2]      = 23'h000200;
    bus.req_writedata[2] = 32'hCAFE0002;
    step();
    n_checks++; if (bus.arb_grant !== 4'b0100) begin n_fail++; $display("FAIL rw_grant: got %b want 0100", bus.arb_grant); end
    n_checks++; if (bus.sdram_read !== 1'b1 || bus.sdram_write !== 1'b0) begin n_fail++; $display("FAIL rw_cmd: got r=%b w=%b want 1 0", bus.sdram_read, bus.sdram_write); end
    n_checks++; if (bus.sdram_writedata !== 32'hCAFE0002) begin n_fail++; $display("FAIL rw_wdata: got %h want cafe0002", bus.sdram_writedata); end
    bus.sdram_finished = 1'b1;
    #1;
    n_checks++; if (bus.req_finished !== 4'b0100) begin n_fail++; $display("FAIL rw_finished: got %b want 0100", bus.req_finished); end
    step();
    clear_inputs();
    step();
  endtask

  // rr_ptr is 3 on entry: scan 3,0,1 picks 1
  task automatic test_withdrawal();
    bus.req_write[1]     = 1'b1;
    bus.req_addr[1]      = 23'h000111;
    bus.req_writedata[1] = 32'h11110000;
    bus.req_write[2]     = 1'b1;
    bus.req_addr[2]      = 23'h000222;
    step();
    n_checks++; if (bus.arb_grant !== 4'b0010 || bus.sdram_write !== 1'b1) begin n_fail++; $display("FAIL wd_grant: got g=%b w=%b want 0010 1", bus.arb_grant, bus.sdram_write); end
    n_checks++; if (bus.sdram_writedata !== 32'h11110000 || bus.sdram_addr !== 23'h000111) begin n_fail++; $display("FAIL wd_bus: got d=%h a=%h want 11110000 000111", bus.sdram_writedata, bus.sdram_addr); end
    step();
    bus.req_write[1] = 1'b0;
    #1;
    n_checks++; if (bus.sdram_write !== 1'b0 || bus.sdram_read !== 1'b0 || bus.req_finished !== 4'b0000) begin n_fail++; $display("FAIL wd_drop: got w=%b r=%b fin=%b want 0 0 0000", bus.sdram_write, bus.sdram_read, bus.req_finished); end
    step();
    n_checks++; if (bus.arb_grant !== 4'b0000) begin n_fail++; $display("FAIL wd_idle: got %b want 0000", bus.arb_grant); end
    step();
    n_checks++; if (bus.arb_grant !== 4'b0100 || bus.sdram_addr !== 23'h000222) begin n_fail++; $display("FAIL wd_next: got g=%b a=%h want 0100 000222", bus.arb_grant, bus.sdram_addr); end
    bus.sdram_finished = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  // rr_ptr is 3 on entry
  task automatic test_reset_mid_op();
    bus.req_read[3] = 1'b1;
    bus.req_addr[3] = 23'h000333;
    step();
    n_checks++; if (bus.arb_grant !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_grant: got %b want 1000", bus.arb_grant); end
    rst_n = 1'b0;
    bus.req_read[0] = 1'b1;
    bus.req_addr[0] = 23'h000044;
    step();
    n_checks++; if (bus.arb_grant !== 4'b0000 || bus.sdram_read !== 1'b0 || bus.sdram_addr !== 23'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got g=%b r=%b a=%h want 0000 0 0", bus.arb_grant, bus.sdram_read, bus.sdram_addr); end
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.arb_grant !== 4'b0001 || bus.sdram_addr !== 23'h000044) begin n_fail++; $display("FAIL rst_mid_regrant: got g=%b a=%h want 0001 000044", bus.arb_grant, bus.sdram_addr); end
    bus.sdram_finished = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  // rr_ptr is 1 on entry
  task automatic test_timeout();
    bus.req_read[1] = 1'b1;
    bus.req_read[2] = 1'b1;
    step();
    n_checks++; if (bus.arb_grant !== 4'b0010 || bus.arb_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_grant: got g=%b t=%b want 0010 0", bus.arb_grant, bus.arb_timeout); end
    for (int i = 1; i < 16; i++) begin
      step();
      n_checks++; if (bus.arb_timeout !== 1'b0 || bus.arb_grant !== 4'b0010) begin n_fail++; $display("FAIL tmo_wait[%0d]: got t=%b g=%b want 0 0010", i, bus.arb_timeout, bus.arb_grant); end
    end
    step();
`ifdef SDRAM_ARB_TIMEOUT_EN
    n_checks++; if (bus.arb_timeout !== 1'b1 || bus.arb_grant !== 4'b0000 || bus.req_finished !== 4'b0000) begin n_fail++; $display("FAIL tmo_pulse: got t=%b g=%b fin=%b want 1 0000 0000", bus.arb_timeout, bus.arb_grant, bus.req_finished); end
    step();
    n_checks++; if (bus.arb_timeout !== 1'b0 || bus.arb_grant !== 4'b0100) begin n_fail++; $display("FAIL tmo_next: got t=%b g=%b want 0 0100", bus.arb_timeout, bus.arb_grant); end
`else
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.arb_timeout !== 1'b0 || bus.arb_grant !== 4'b0010) begin n_fail++; $display("FAIL notmo_hold[%0d]: got t=%b g=%b want 0 0010", i, bus.arb_timeout, bus.arb_grant); end
      step();
    end
`endif
    bus.sdram_finished = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_finished_idle();
    test_round_robin();
    test_read_write();
    test_withdrawal();
    test_reset_mid_op();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
